// File: rtl/pps_pkg.sv
// Shared definitions for the 1PPS transmit/receive pair: state encoding,
// default timing constants, counter sizing and adjustment saturation.
package pps_pkg;

    localparam int unsigned PPS_DEFAULT_FREQUENCY   = 125_000_000;
    localparam int unsigned PPS_DEFAULT_PULSE_WIDTH = 12_500_000;

    typedef enum logic {
        PPS_IDLE = 1'b0,
        PPS_RUN  = 1'b1
    } pps_state_e;

    // Wide enough for a nominal period stretched by up to half a second.
    function automatic int pps_cnt_width(input int unsigned freq);
        return $clog2(freq + freq / 2);
    endfunction

    function automatic logic signed [31:0] pps_sat_offset(
        input logic signed [31:0] off,
        input int unsigned        lim
    );
        logic signed [31:0] lim_s;
        lim_s = $signed(lim);
        if (off > lim_s) begin
            return lim_s;
        end else if (off < -lim_s) begin
            return -lim_s;
        end
        return off;
    endfunction

endpackage

// File: rtl/pps_period_counter.sv
// Cycle counter for one PPS second: flags the last cycle of the period and
// applies a one-period length adjustment latched at the wrap.
module pps_period_counter
    import pps_pkg::*;
#(
    parameter int unsigned C_CLOCK_FREQUENCY = PPS_DEFAULT_FREQUENCY,
    parameter int          CNT_W             = pps_cnt_width(C_CLOCK_FREQUENCY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_i,
    input  logic             take_adj_i,
    input  logic [CNT_W-1:0] adj_off_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] NOMINAL_END = CNT_W'(C_CLOCK_FREQUENCY - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] adj_q;
    logic [CNT_W-1:0] period_end;

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        // Offset is two's complement; the modulo-2^CNT_W sum is the true end value.
        period_end = NOMINAL_END + adj_q;
        wrap_o     = count_i && (cnt_q == period_end);
        cnt_d      = cnt_q + CNT_W'(1);
        if (!count_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    assign cnt_next_o = cnt_d;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            adj_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!count_i) begin
                adj_q <= '0;
            end else if (wrap_o) begin
                adj_q <= take_adj_i ? adj_off_i : '0;
            end
        end
    end

endmodule

// File: rtl/pps_transmitter.sv
// Local 1PPS generator with one-shot signed phase slewing via valid/ready.
// Optional seconds counter port enabled by PPS_TRANSMITTER_SECONDS_EN.
module pps_transmitter
    import pps_pkg::*;
#(
    parameter int unsigned C_CLOCK_FREQUENCY = PPS_DEFAULT_FREQUENCY,
    parameter int unsigned C_PULSE_WIDTH     = PPS_DEFAULT_PULSE_WIDTH,
    parameter int          C_ADJ_WIDTH       = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          adj_valid,
    output logic                          adj_ready,
    input  logic signed [C_ADJ_WIDTH-1:0] adj_offset,
    output logic                          pps_out,
    output logic                          pps_tick,
    output logic                          running
`ifdef PPS_TRANSMITTER_SECONDS_EN
    ,
    output logic [31:0]                   seconds
`endif
);

    localparam int               CNT_W     = pps_cnt_width(C_CLOCK_FREQUENCY);
    localparam int unsigned      ADJ_LIMIT = C_CLOCK_FREQUENCY / 2 - C_PULSE_WIDTH;
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(C_PULSE_WIDTH);

    pps_state_e       state_q;
    logic             running_q;
    logic             pps_out_q;
    logic             pps_tick_q;
    logic             pending_q;
    logic [CNT_W-1:0] off_q;

    logic             count;
    logic             accept;
    logic             wrap;
    logic [CNT_W-1:0] cnt_next;

    assign count     = (state_q == PPS_RUN) && enable;
    assign adj_ready = running_q && !pending_q;
    assign accept    = adj_valid && adj_ready;

    pps_period_counter #(
        .C_CLOCK_FREQUENCY (C_CLOCK_FREQUENCY),
        .CNT_W             (CNT_W)
    ) u_period_counter (
        .clk        (clk),
        .rst        (rst),
        .count_i    (count),
        .take_adj_i (pending_q),
        .adj_off_i  (off_q),
        .cnt_next_o (cnt_next),
        .wrap_o     (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PPS_IDLE;
            running_q  <= 1'b0;
            pps_out_q  <= 1'b0;
            pps_tick_q <= 1'b0;
            pending_q  <= 1'b0;
            off_q      <= '0;
        end else begin
            case (state_q)
                PPS_IDLE: begin
                    pending_q <= 1'b0;
                    if (enable) begin
                        state_q    <= PPS_RUN;
                        running_q  <= 1'b1;
                        pps_out_q  <= 1'b1;
                        pps_tick_q <= 1'b1;
                    end else begin
                        running_q  <= 1'b0;
                        pps_out_q  <= 1'b0;
                        pps_tick_q <= 1'b0;
                    end
                end
                PPS_RUN: begin
                    if (!enable) begin
                        // A pulse in progress is cut short; any pending slew is discarded.
                        state_q    <= PPS_IDLE;
                        running_q  <= 1'b0;
                        pps_out_q  <= 1'b0;
                        pps_tick_q <= 1'b0;
                        pending_q  <= 1'b0;
                    end else begin
                        pps_out_q  <= (cnt_next < PULSE_END);
                        pps_tick_q <= wrap;
                        if (accept) begin
                            pending_q <= 1'b1;
                            off_q     <= CNT_W'(pps_sat_offset(32'(adj_offset), ADJ_LIMIT));
                        end else if (wrap) begin
                            pending_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= PPS_IDLE;
                end
            endcase
        end
    end

    assign pps_out  = pps_out_q;
    assign pps_tick = pps_tick_q;
    assign running  = running_q;

`ifdef PPS_TRANSMITTER_SECONDS_EN
    logic [31:0] seconds_q;

    // Counts every rising edge of pps_out, including the first after enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            seconds_q <= '0;
        end else if (((state_q == PPS_IDLE) && enable) || wrap) begin
            seconds_q <= seconds_q + 32'd1;
        end
    end

    assign seconds = seconds_q;
`endif

endmodule
